// File: rtl/cpu_pkg.sv
// Shared size codes, FSM states and captured request bundle
// for the load/store stage.
package cpu_pkg;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;

  typedef enum logic {
    IDLE,
    BUSY
  } mem_state_e;

  typedef struct packed {
    logic [1:0] lo;
    logic [1:0] size;
    logic       sext;
    logic       load;
    logic       wreg;
    logic [4:0] rn;
  } mem_req_t;

endpackage

// File: rtl/mem_align.sv
// Byte-lane steering: store enables/replication and
// load-lane extraction with zero/sign extension.
module mem_align (
  input  logic [1:0]  lo,
  input  logic [1:0]  size,
  input  logic        sext,
  input  logic [31:0] sdata,
  input  logic [31:0] rdata,
  output logic [3:0]  be,
  output logic [31:0] wdata,
  output logic [31:0] ldata
);
  import cpu_pkg::*;

  logic [7:0]  byte_l;
  logic [15:0] half_l;

  assign byte_l = rdata[{lo, 3'b000} +: 8];
  assign half_l = lo[1] ? rdata[31:16] : rdata[15:0];

  always_comb begin
    be    = 4'b1111;
    wdata = sdata;
    ldata = rdata;
    unique case (size)
      SZ_B: begin
        be    = 4'b0001 << lo;
        wdata = {4{sdata[7:0]}};
        ldata = {{24{sext & byte_l[7]}}, byte_l};
      end
      SZ_H: begin
        be    = lo[1] ? 4'b1100 : 4'b0011;
        wdata = {2{sdata[15:0]}};
        ldata = {{16{sext & half_l[15]}}, half_l};
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// Load/store stage: single-outstanding req/ack data bus,
// pipeline stall while pending, registered write-back result.
module mem_stage #(
  parameter int unsigned ACK_TIMEOUT = 255
) (
  input  logic        clock,
  input  logic        resetn,
  input  logic        mvalid,
  input  logic        mrmem,
  input  logic        mwmem,
  input  logic [1:0]  msize,
  input  logic        msext,
  input  logic [31:0] maddr,
  input  logic [31:0] mdata,
  input  logic [4:0]  mrn,
  input  logic        mwreg,
  output logic        stall,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata,
  output logic        wvalid,
  output logic [31:0] wdata,
  output logic [4:0]  wrn,
  output logic        wwreg,
  output logic        wexc
);
  import cpu_pkg::*;

  localparam logic [15:0] CNT_LAST =
    16'(ACK_TIMEOUT - 1);

  mem_state_e  state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  mem_req_t    cap_q, cap_d;

  logic        req_q, req_d;
  logic        we_q, we_d;
  logic [3:0]  be_q, be_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] bwd_q, bwd_d;
  logic        wvalid_q, wvalid_d;
  logic [31:0] wdata_q, wdata_d;
  logic [4:0]  wrn_q, wrn_d;
  logic        wwreg_q, wwreg_d;
  logic        wexc_q, wexc_d;

  logic        busy, is_mem, misal;
  logic        accept, timeout;
  logic [1:0]  a_lo, a_size;
  logic [3:0]  a_be;
  logic [31:0] a_wdata, a_ldata;

  assign busy   = (state_q == BUSY);
  assign is_mem = mrmem | mwmem;
  assign misal  = (msize[1] & |maddr[1:0])
                | ((msize == SZ_H) & maddr[0]);
  assign accept = !busy & mvalid & is_mem & !misal;
  assign timeout = busy & (cnt_q == CNT_LAST);

  // Held in reset means nothing may be stalled upstream.
  assign stall = resetn &
    (accept | (busy & !dmem_ack & !timeout));

  assign a_lo   = busy ? cap_q.lo   : maddr[1:0];
  assign a_size = busy ? cap_q.size : msize;

  mem_align u_align (
    .lo    (a_lo),
    .size  (a_size),
    .sext  (cap_q.sext),
    .sdata (mdata),
    .rdata (dmem_rdata),
    .be    (a_be),
    .wdata (a_wdata),
    .ldata (a_ldata)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    cap_d    = cap_q;
    req_d    = req_q;
    we_d     = we_q;
    be_d     = be_q;
    addr_d   = addr_q;
    bwd_d    = bwd_q;
    wvalid_d = 1'b0;
    wdata_d  = wdata_q;
    wrn_d    = wrn_q;
    wwreg_d  = wwreg_q;
    wexc_d   = wexc_q;
    unique case (state_q)
      IDLE: begin
        unique case (1'b1)
          !mvalid: ;
          accept: begin
            state_d    = BUSY;
            cnt_d      = '0;
            cap_d.lo   = maddr[1:0];
            cap_d.size = msize;
            cap_d.sext = msext;
            cap_d.load = mrmem;
            cap_d.wreg = mwreg;
            cap_d.rn   = mrn;
            req_d      = 1'b1;
            we_d       = mwmem;
            be_d       = a_be;
            addr_d     = {maddr[31:2], 2'b00};
            bwd_d      = a_wdata;
          end
          default: begin
            wvalid_d = 1'b1;
            wdata_d  = maddr;
            wrn_d    = mrn;
            wwreg_d  = mwreg & !is_mem;
            wexc_d   = is_mem;
          end
        endcase
      end
      BUSY: begin
        if (dmem_ack) begin
          state_d  = IDLE;
          cnt_d    = '0;
          req_d    = 1'b0;
          wvalid_d = 1'b1;
          wrn_d    = cap_q.rn;
          wexc_d   = 1'b0;
          wwreg_d  = cap_q.load & cap_q.wreg;
          wdata_d  = cap_q.load ? a_ldata
                   : {addr_q[31:2], cap_q.lo};
        end else if (timeout) begin
          state_d  = IDLE;
          cnt_d    = '0;
          req_d    = 1'b0;
          wvalid_d = 1'b1;
          wrn_d    = cap_q.rn;
          wexc_d   = 1'b1;
          wwreg_d  = 1'b0;
          wdata_d  = {addr_q[31:2], cap_q.lo};
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      cap_q    <= '0;
      req_q    <= 1'b0;
      we_q     <= 1'b0;
      be_q     <= '0;
      addr_q   <= '0;
      bwd_q    <= '0;
      wvalid_q <= 1'b0;
      wdata_q  <= '0;
      wrn_q    <= '0;
      wwreg_q  <= 1'b0;
      wexc_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      cap_q    <= cap_d;
      req_q    <= req_d;
      we_q     <= we_d;
      be_q     <= be_d;
      addr_q   <= addr_d;
      bwd_q    <= bwd_d;
      wvalid_q <= wvalid_d;
      wdata_q  <= wdata_d;
      wrn_q    <= wrn_d;
      wwreg_q  <= wwreg_d;
      wexc_q   <= wexc_d;
    end
  end

  assign dmem_req   = req_q;
  assign dmem_we    = we_q;
  assign dmem_be    = be_q;
  assign dmem_addr  = addr_q;
  assign dmem_wdata = bwd_q;
  assign wvalid     = wvalid_q;
  assign wdata      = wdata_q;
  assign wrn        = wrn_q;
  assign wwreg      = wwreg_q;
  assign wexc       = wexc_q;

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: directed vector table, randomized ops
// against an arithmetic reference model, reset/timeout cases.
module tb_mem_stage;

  localparam int TO = 4;

  logic        clock = 1'b0;
  logic        resetn = 1'b0;
  logic        mvalid = 1'b0;
  logic        mrmem = 1'b0;
  logic        mwmem = 1'b0;
  logic [1:0]  msize = 2'b00;
  logic        msext = 1'b0;
  logic [31:0] maddr = '0;
  logic [31:0] mdata = '0;
  logic [4:0]  mrn = '0;
  logic        mwreg = 1'b0;
  logic        stall;
  logic        dmem_req;
  logic        dmem_we;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic        dmem_ack = 1'b0;
  logic [31:0] dmem_rdata = '0;
  logic        wvalid;
  logic [31:0] wdata;
  logic [4:0]  wrn;
  logic        wwreg;
  logic        wexc;

  int total = 0;
  int bad = 0;

  always #5 clock = ~clock;

  mem_stage #(.ACK_TIMEOUT(TO)) dut (
    .clock      (clock),
    .resetn     (resetn),
    .mvalid     (mvalid),
    .mrmem      (mrmem),
    .mwmem      (mwmem),
    .msize      (msize),
    .msext      (msext),
    .maddr      (maddr),
    .mdata      (mdata),
    .mrn        (mrn),
    .mwreg      (mwreg),
    .stall      (stall),
    .dmem_req   (dmem_req),
    .dmem_we    (dmem_we),
    .dmem_be    (dmem_be),
    .dmem_addr  (dmem_addr),
    .dmem_wdata (dmem_wdata),
    .dmem_ack   (dmem_ack),
    .dmem_rdata (dmem_rdata),
    .wvalid     (wvalid),
    .wdata      (wdata),
    .wrn        (wrn),
    .wwreg      (wwreg),
    .wexc       (wexc)
  );

  typedef struct {
    logic        rd;
    logic        wr;
    logic [1:0]  sz;
    logic        sx;
    logic [31:0] addr;
    logic [31:0] data;
    logic [4:0]  rn;
    logic        wreg;
    logic [31:0] rdata;
    int          ack_at;
    logic        bus;
    logic [3:0]  be;
    logic [31:0] bwd;
    logic [31:0] res;
    logic        exc;
    logic        wwreg;
  } vec_t;

  vec_t tbl[14];

  task automatic chk1(input string nm,
                      input logic act,
                      input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b want %b", nm, act, exp);
    end
  endtask

  task automatic chk32(input string nm,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(
    input logic rd, input logic wr,
    input logic [1:0] sz, input logic sx,
    input logic [31:0] addr, input logic [31:0] data,
    input logic [4:0] rn, input logic wreg,
    input logic [31:0] rdata, input int ack_at,
    input logic bus, input logic [3:0] be,
    input logic [31:0] bwd, input logic [31:0] res,
    input logic exc, input logic ww);
    vec_t v;
    v.rd = rd; v.wr = wr; v.sz = sz; v.sx = sx;
    v.addr = addr; v.data = data; v.rn = rn;
    v.wreg = wreg; v.rdata = rdata; v.ack_at = ack_at;
    v.bus = bus; v.be = be; v.bwd = bwd; v.res = res;
    v.exc = exc; v.wwreg = ww;
    return v;
  endfunction

  // Reference: lane math on byte counts, not bit decoding.
  function automatic vec_t model(input vec_t v);
    vec_t   r;
    int     nb, lane, base;
    longint val;
    logic   mem, mis, to;
    r    = v;
    nb   = (v.sz == 2'b00) ? 1 : (v.sz == 2'b01) ? 2 : 4;
    lane = int'(v.addr[1:0]);
    base = lane - (lane % nb);
    mem  = v.rd | v.wr;
    mis  = mem && ((lane % nb) != 0);
    r.bus = mem && !mis;
    to   = r.bus && (v.ack_at == 0 || v.ack_at > TO);
    r.be = 4'(((1 << nb) - 1) << base);
    for (int i = 0; i < 4; i++)
      r.bwd[8*i +: 8] = v.data[8*(i % nb) +: 8];
    val = longint'(v.rdata) >> (8 * base);
    if (nb < 4) begin
      val = val & ((longint'(1) << (8 * nb)) - 1);
      if (v.sx && val >= (longint'(1) << (8 * nb - 1)))
        val = val - (longint'(1) << (8 * nb));
    end
    r.res   = (r.bus && v.rd) ? 32'(val) : v.addr;
    r.exc   = mis || to;
    r.wwreg = v.wreg && !r.exc && !v.wr;
    return r;
  endfunction

  task automatic do_op(input vec_t v);
    int n;
    bit done;
    @(posedge clock); #1;
    mrmem = v.rd; mwmem = v.wr; msize = v.sz;
    msext = v.sx; maddr = v.addr; mdata = v.data;
    mrn = v.rn; mwreg = v.wreg; mvalid = 1'b1;
    dmem_ack = 1'b0;
    @(negedge clock);
    chk1("c0_stall", stall, v.bus);
    chk1("c0_req", dmem_req, 1'b0);
    if (v.bus) begin
      n = 0;
      done = 0;
      while (!done) begin
        @(posedge clock); #1;
        n++;
        dmem_ack = (n == v.ack_at);
        dmem_rdata = dmem_ack ? v.rdata : $urandom;
        @(negedge clock);
        chk1("req", dmem_req, 1'b1);
        chk1("we", dmem_we, v.wr);
        chk32("be", 32'(dmem_be), 32'(v.be));
        chk32("addr", dmem_addr, {v.addr[31:2], 2'b00});
        if (v.wr) chk32("bwdata", dmem_wdata, v.bwd);
        chk1("wvalid_busy", wvalid, 1'b0);
        done = dmem_ack || (n >= TO);
        chk1("stall_busy", stall, !done);
      end
    end
    @(posedge clock); #1;
    dmem_ack = 1'b0;
    mvalid = 1'b0;
    @(negedge clock);
    chk1("wvalid", wvalid, 1'b1);
    chk1("wexc", wexc, v.exc);
    chk1("wwreg", wwreg, v.wwreg);
    chk1("req_done", dmem_req, 1'b0);
    chk1("stall_done", stall, 1'b0);
    if (!v.exc) chk32("wrn", 32'(wrn), 32'(v.rn));
    if (!v.bus || (v.rd && !v.exc))
      chk32("wdata", wdata, v.res);
    @(posedge clock); #1;
    @(negedge clock);
    chk1("wvalid_once", wvalid, 1'b0);
  endtask

  initial begin
    vec_t v;
    int op;

    tbl[0]  = mk(0,0,2'd2,0,'h1234,0,5,1,0,0,
                 0,4'h0,0,'h1234,0,1);
    tbl[1]  = mk(1,0,2'd0,1,'h103,0,7,1,'h80AABBCC,1,
                 1,4'b1000,0,'hFFFFFF80,0,1);
    tbl[2]  = mk(0,1,2'd1,0,'h202,'h12345678,3,1,0,3,
                 1,4'b1100,'h56785678,0,0,0);
    tbl[3]  = mk(1,0,2'd2,0,'h301,0,4,1,0,1,
                 0,4'h0,0,'h301,1,0);
    tbl[4]  = mk(1,0,2'd1,0,'h102,0,8,1,'h80AABBCC,2,
                 1,4'b1100,0,'h000080AA,0,1);
    tbl[5]  = mk(1,0,2'd1,1,'h100,0,9,1,'h1234F00D,1,
                 1,4'b0011,0,'hFFFFF00D,0,1);
    tbl[6]  = mk(0,1,2'd0,0,'h3,'hA5,1,0,0,2,
                 1,4'b1000,'hA5A5A5A5,0,0,0);
    tbl[7]  = mk(0,1,2'd2,0,'h40,'hDEADBEEF,2,1,0,4,
                 1,4'b1111,'hDEADBEEF,0,0,0);
    tbl[8]  = mk(1,0,2'd1,1,'h101,0,6,1,0,1,
                 0,4'h0,0,'h101,1,0);
    tbl[9]  = mk(1,0,2'd3,1,'h8,0,10,1,'hCAFEF00D,1,
                 1,4'b1111,0,'hCAFEF00D,0,1);
    tbl[10] = mk(1,0,2'd2,0,'h10,0,11,1,0,0,
                 1,4'b1111,0,0,1,0);
    tbl[11] = mk(0,0,2'd0,0,'hFFFFFFFF,0,31,0,0,0,
                 0,4'h0,0,'hFFFFFFFF,0,0);
    tbl[12] = mk(1,0,2'd0,0,'h101,0,12,1,'h80AABBCC,1,
                 1,4'b0010,0,'h000000BB,0,1);
    tbl[13] = mk(0,1,2'd2,0,'h44,'h1,13,1,0,5,
                 1,4'b1111,'h1,0,1,0);

    // Reset with a load presented: everything must read 0.
    mvalid = 1'b1; mrmem = 1'b1; msize = 2'd2;
    maddr = 'h20;
    #12;
    chk1("rst_stall", stall, 1'b0);
    chk1("rst_req", dmem_req, 1'b0);
    chk1("rst_we", dmem_we, 1'b0);
    chk32("rst_be", 32'(dmem_be), 0);
    chk32("rst_addr", dmem_addr, 0);
    chk32("rst_bwd", dmem_wdata, 0);
    chk1("rst_wvalid", wvalid, 1'b0);
    chk32("rst_wdata", wdata, 0);
    chk32("rst_wrn", 32'(wrn), 0);
    chk1("rst_wwreg", wwreg, 1'b0);
    chk1("rst_wexc", wexc, 1'b0);
    mvalid = 1'b0; mrmem = 1'b0;
    @(posedge clock); #1;
    resetn = 1'b1;

    for (int i = 0; i < 14; i++) do_op(tbl[i]);

    // Ack arriving after a timeout, in IDLE.
    do_op(tbl[10]);
    @(posedge clock); #1;
    dmem_ack = 1'b1;
    @(negedge clock);
    chk1("late_ack_stall", stall, 1'b0);
    @(posedge clock); #1;
    dmem_ack = 1'b0;
    @(negedge clock);
    chk1("late_ack_wvalid", wvalid, 1'b0);
    chk1("late_ack_req", dmem_req, 1'b0);

    // Back-to-back non-memory ops.
    @(posedge clock); #1;
    mrmem = 0; mwmem = 0; mvalid = 1;
    maddr = 'hAAAA0001; mrn = 1; mwreg = 1;
    @(posedge clock); #1;
    maddr = 'hBBBB0002; mrn = 2;
    @(negedge clock);
    chk1("b2b_v0", wvalid, 1'b1);
    chk32("b2b_d0", wdata, 'hAAAA0001);
    @(posedge clock); #1;
    mvalid = 0;
    @(negedge clock);
    chk1("b2b_v1", wvalid, 1'b1);
    chk32("b2b_d1", wdata, 'hBBBB0002);
    chk32("b2b_rn1", 32'(wrn), 2);
    @(posedge clock); #1;
    @(negedge clock);
    chk1("b2b_v2", wvalid, 1'b0);

    // Reset pulse while BUSY.
    @(posedge clock); #1;
    mrmem = 1; mwmem = 0; msize = 2'd2;
    maddr = 'h500; mrn = 3; mvalid = 1;
    @(posedge clock); #1;
    @(negedge clock);
    chk1("pre_rst_req", dmem_req, 1'b1);
    @(posedge clock); #2;
    resetn = 1'b0;
    #1;
    chk1("mid_rst_req", dmem_req, 1'b0);
    chk1("mid_rst_stall", stall, 1'b0);
    chk1("mid_rst_wvalid", wvalid, 1'b0);
    mvalid = 0; mrmem = 0;
    @(posedge clock); #1;
    resetn = 1'b1;
    @(negedge clock);
    chk1("post_rst_wvalid", wvalid, 1'b0);
    chk1("post_rst_req", dmem_req, 1'b0);
    do_op(tbl[1]);

    // Randomized ops against the reference model.
    for (int i = 0; i < 60; i++) begin
      op = $urandom_range(2);
      v.rd = (op == 1);
      v.wr = (op == 2);
      v.sz = 2'($urandom_range(3));
      v.sx = 1'($urandom_range(1));
      v.addr = $urandom;
      v.data = $urandom;
      v.rn = 5'($urandom_range(31));
      v.wreg = 1'($urandom_range(1));
      v.rdata = $urandom;
      v.ack_at = $urandom_range(TO + 1);
      do_op(model(v));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
